// File: rtl/exp_frame.sv
`default_nettype none
// ============================================================================
// Module      : exp_frame
// Description : Converts a frame of log-domain bin values back to linear
//               power. A frame is accepted on a valid/ready handshake, then
//               one bin is expanded per cycle. The finished frame is held on
//               data_o until the downstream stage accepts it.
//               Optional feature macro: EXP_SAT_FLAG_EN adds the sat_o flag
//               (set when any bin of the frame saturated).
// Revision    : 1.0 - initial release
// ============================================================================
module exp_frame #(
    parameter int I_BW  = 14,
    parameter int O_BW  = 30,
    parameter int SHIFT = 10,
    parameter int NBINS = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [I_BW*NBINS-1:0]   data_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [O_BW*NBINS-1:0]   data_o
`ifdef EXP_SAT_FLAG_EN
    ,
    output logic                    sat_o
`endif
);

    localparam int IDX_W = $clog2(NBINS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [I_BW*NBINS-1:0]   frame_q;
    logic                    accept;
    logic                    last_bin;

    logic signed [I_BW-1:0]  bin_x;
    logic signed [31:0]      bin_e;
    logic [O_BW-1:0]         bin_y;
    logic                    bin_sat;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_bin  = (idx == IDX_W'(NBINS - 1));

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, step through every bin, wait for consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_bin) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-bin expansion: e = x*7/5 - SHIFT (truncating), then 2^(e-1) or clamp.
    always_comb begin
        bin_x   = frame_q[idx*I_BW +: I_BW];
        bin_e   = (32'(bin_x) * 32'sd7) / 32'sd5 - 32'(SHIFT);
        bin_y   = '0;
        bin_sat = 1'b0;
        if (bin_e < 32'sd1) begin
            bin_y = '0;
        end else if (bin_e > 32'(O_BW)) begin
            bin_y   = '1;
            bin_sat = 1'b1;
        end else begin
            bin_y = O_BW'(1) << (bin_e - 32'sd1);
        end
    end

    // Frame capture, bin index walk and output slice writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            frame_q <= '0;
            data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame_q <= data_i;
                        idx     <= '0;
                    end
                end
                CALC: begin
                    data_o[idx*O_BW +: O_BW] <= bin_y;
                    if (!last_bin) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef EXP_SAT_FLAG_EN
    // Sticky saturation flag: cleared on acceptance, held through DONE/IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_o <= 1'b0;
        end else if (accept) begin
            sat_o <= 1'b0;
        end else if (state == CALC && bin_sat) begin
            sat_o <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_exp_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_frame
// Description : Self-checking bench for exp_frame with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_frame;

    localparam int I_BW  = 14;
    localparam int O_BW  = 30;
    localparam int SHIFT = 10;
    localparam int NBINS = 64;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [I_BW*NBINS-1:0]   data_i;
    logic                    out_valid;
    logic                    out_ready;
    logic [O_BW*NBINS-1:0]   data_o;
`ifdef EXP_SAT_FLAG_EN
    logic                    sat_o;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int frame[NBINS];

    exp_frame #(
        .I_BW  (I_BW),
        .O_BW  (O_BW),
        .SHIFT (SHIFT),
        .NBINS (NBINS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_i    (data_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o)
`ifdef EXP_SAT_FLAG_EN
        ,
        .sat_o     (sat_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Linear value of one log bin, straight from the conversion rule.
    function automatic longint model_bin(input int x);
        int e;
        e = (x * 7) / 5 - SHIFT;
        if (e < 1)         return 0;
        else if (e > O_BW) return (longint'(1) << O_BW) - 1;
        else               return longint'(1) << (e - 1);
    endfunction

    function automatic bit model_sat();
        for (int n = 0; n < NBINS; n++)
            if ((frame[n] * 7) / 5 - SHIFT > O_BW) return 1'b1;
        return 1'b0;
    endfunction

    function automatic longint get_bin(input int n);
        return longint'(data_o[n*O_BW +: O_BW]);
    endfunction

    task automatic load_frame();
        for (int n = 0; n < NBINS; n++)
            data_i[n*I_BW +: I_BW] = I_BW'(frame[n]);
    endtask

    task automatic rand_frame(input bit wide);
        for (int n = 0; n < NBINS; n++)
            frame[n] = wide ? int'($urandom_range(0, 16383)) - 8192
                            : int'($urandom_range(0, 60)) - 20;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    // Presents frame[], returns edges from acceptance until out_valid.
    task automatic send_frame(output int lat);
        load_frame();
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic check_frame(input string tag);
        for (int n = 0; n < NBINS; n++)
            check(tag, get_bin(n), model_bin(frame[n]));
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", longint'(out_valid), 0);
        check("ready_back", longint'(in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rises;
        int prev_acc;
        int acc;
        logic [O_BW*NBINS-1:0] snap;
        int fr[3][NBINS];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_data_zero", longint'(|data_o), 0);
`ifdef EXP_SAT_FLAG_EN
        check("rst_sat", longint'(sat_o), 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed frame with known constants
        for (int n = 0; n < NBINS; n++) frame[n] = 29;
        frame[0] = 15; frame[1] = 8; frame[2] = 7; frame[3] = -5;
        send_frame(lat);
        check("latency", lat, NBINS);
        check("dir_bin0", get_bin(0), 1024);
        check("dir_bin1", get_bin(1), 1);
        check("dir_bin2", get_bin(2), 0);
        check("dir_bin3", get_bin(3), 0);
        check("dir_bin4", get_bin(4), 64'h2000_0000);
        check("dir_bin63", get_bin(63), 64'h2000_0000);
        check_frame("dir_frame");
        check("done_in_ready", longint'(in_ready), 0);
`ifdef EXP_SAT_FLAG_EN
        check("dir_sat", longint'(sat_o), 0);
`endif

        // Backpressure: DONE held, new in_valid must be ignored
        snap = data_o;
        for (int n = 0; n < NBINS; n++) data_i[n*I_BW +: I_BW] = I_BW'(n);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", longint'(out_valid), 1);
            check("bp_ready", longint'(in_ready), 0);
            check("bp_stable", longint'(data_o == snap), 1);
        end
        release_frame();
        in_valid = 1'b0;
        check("idle_hold", longint'(data_o == snap), 1);
        repeat (3) @(posedge clk);
        #1;
        check("no_accept", longint'(in_ready), 1);

        // Saturation then clean frame
        for (int n = 0; n < NBINS; n++) frame[n] = 15;
        frame[5] = 30;
        send_frame(lat);
        check("sat_latency", lat, NBINS);
        check("sat_bin", get_bin(5), 64'h3FFF_FFFF);
        check_frame("sat_frame");
`ifdef EXP_SAT_FLAG_EN
        check("sat_flag", longint'(sat_o), 1);
`endif
        release_frame();
        frame[5] = 15;
        send_frame(lat);
        check_frame("clean_frame");
`ifdef EXP_SAT_FLAG_EN
        check("sat_clear", longint'(sat_o), 0);
`endif
        release_frame();
`ifdef EXP_SAT_FLAG_EN
        check("sat_idle_hold", longint'(sat_o), 0);
`endif

        // Randomized frames with random consumer delay
        for (int f = 0; f < 6; f++) begin
            rand_frame(f[0]);
            send_frame(lat);
            check("rnd_latency", lat, NBINS);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                check("rnd_hold_valid", longint'(out_valid), 1);
            end
            check_frame("rnd_frame");
`ifdef EXP_SAT_FLAG_EN
            check("rnd_sat", longint'(sat_o), longint'(model_sat()));
`endif
            release_frame();
        end

        // Reset during CALC at idx 20
        rand_frame(1'b0);
        load_frame();
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_ready", longint'(in_ready), 1);
        check("abort_valid", longint'(out_valid), 0);
        check("abort_data", longint'(|data_o), 0);
        rises = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        check("abort_no_valid", rises, 0);

        // Back-to-back with in_valid held and out_ready high
        for (int f = 0; f < 3; f++) begin
            rand_frame(1'b0);
            fr[f] = frame;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev_acc  = 0;
        for (int f = 0; f < 3; f++) begin
            frame = fr[f];
            load_frame();
            wait_ready();
            @(posedge clk); #1;
            acc = cyc;
            if (f > 0) check("b2b_period", acc - prev_acc, NBINS + 2);
            prev_acc = acc;
            if (f < 2) begin
                frame = fr[f+1];
                load_frame();
            end else begin
                in_valid = 1'b0;
            end
            lat = 0;
            while (!out_valid && lat < 200) begin
                @(posedge clk); #1; lat++;
            end
            check("b2b_latency", lat, NBINS);
            frame = fr[f];
            check_frame("b2b_frame");
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_end_valid", longint'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
